// File: rtl/lsu.sv
// lsu: load/store stage between execute and wbu; one request/response memory transaction per load/store.
// Build option LSU_MISALIGN_CHECK_EN: misaligned half/word accesses skip memory and complete with excp_flush.
module lsu #(
  parameter  int ADDR_W            = 32,
  localparam int LSU_WBU_BUS_WIDTH = 119,
  localparam int EXU_LSU_BUS_WIDTH = 156
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         exu_valid_i,
  input  logic [EXU_LSU_BUS_WIDTH-1:0] exu_lsu_bus_i,
  output logic                         lsu_ready_o,
  output logic                         req_valid_o,
  input  logic                         req_ready_i,
  output logic                         req_wen_o,
  output logic [ADDR_W-1:0]            req_addr_o,
  output logic [31:0]                  req_wdata_o,
  output logic [3:0]                   req_wmask_o,
  input  logic                         resp_valid_i,
  input  logic [31:0]                  resp_rdata_i,
  output logic                         lsu_valid_o,
  output logic [LSU_WBU_BUS_WIDTH-1:0] lsu_wbu_bus_o
);

  // Record bit positions: {csr_we, final_result, gr_we, rd, csr_addr, csr_wdata, jmp_flag, jmp_target, break, excp_flush, xret_flush}
  localparam int EXCP_BIT  = 1;
  localparam int FR_LSB    = 86;
  localparam int GRWE_BIT  = 85;
  localparam int CSRWE_BIT = 118;
  localparam int WDATA_LSB = 119;
  localparam int OP_LSB    = 151;
  localparam int WE_BIT    = 154;
  localparam int RE_BIT    = 155;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] off,
                                               input logic [31:0] rdata);
    logic [31:0] sh_b;
    logic [31:0] sh_h;
    sh_b = rdata >> {off, 3'b000};
    sh_h = rdata >> {off[1], 4'b0000};
    case (op)
      3'b000:  return {{24{sh_b[7]}}, sh_b[7:0]};
      3'b100:  return {24'h00_0000, sh_b[7:0]};
      3'b001:  return {{16{sh_h[15]}}, sh_h[15:0]};
      3'b101:  return {16'h0000, sh_h[15:0]};
      default: return rdata;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] wdata);
    case (op)
      3'b000, 3'b100: return {4{wdata[7:0]}};
      3'b001, 3'b101: return {2{wdata[15:0]}};
      default:        return wdata;
    endcase
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] op, input logic [1:0] off);
    case (op)
      3'b000, 3'b100: return 4'b0001 << off;
      3'b001, 3'b101: return 4'b0011 << {off[1], 1'b0};
      default:        return 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] off);
    case (op)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return off[0];
      default:        return (off != 2'b00);
    endcase
  endfunction

  state_e                         state_q, state_d;
  logic [LSU_WBU_BUS_WIDTH-1:0]   rec_q, rec_d;
  logic [LSU_WBU_BUS_WIDTH-1:0]   out_q, out_d;
  logic                           is_load_q, is_load_d;
  logic [2:0]                     op_q, op_d;
  logic [1:0]                     off_q, off_d;
  logic                           ready_q, ready_d;
  logic                           req_valid_q, req_valid_d;
  logic                           req_wen_q, req_wen_d;
  logic [ADDR_W-1:0]              req_addr_q, req_addr_d;
  logic [31:0]                    req_wdata_q, req_wdata_d;
  logic [3:0]                     req_wmask_q, req_wmask_d;
  logic                           lsu_valid_q, lsu_valid_d;

  logic [LSU_WBU_BUS_WIDTH-1:0]   in_rec_s;
  logic [31:0]                    in_addr_s;
  logic [2:0]                     in_op_s;
  logic                           in_mem_s;
  logic                           in_misalign_s;

  assign in_rec_s  = exu_lsu_bus_i[LSU_WBU_BUS_WIDTH-1:0];
  assign in_addr_s = in_rec_s[FR_LSB +: 32];
  assign in_op_s   = exu_lsu_bus_i[OP_LSB +: 3];
  assign in_mem_s  = exu_lsu_bus_i[RE_BIT] | exu_lsu_bus_i[WE_BIT];
`ifdef LSU_MISALIGN_CHECK_EN
  assign in_misalign_s = in_mem_s & misaligned(in_op_s, in_addr_s[1:0]);
`else
  assign in_misalign_s = 1'b0;
`endif

  // Next-state and next-output computation for the IDLE/REQ/WAIT/DONE sequence
  always_comb begin
    state_d     = state_q;
    rec_d       = rec_q;
    out_d       = out_q;
    is_load_d   = is_load_q;
    op_d        = op_q;
    off_d       = off_q;
    ready_d     = ready_q;
    req_valid_d = req_valid_q;
    req_wen_d   = req_wen_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wmask_d = req_wmask_q;
    lsu_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (exu_valid_i) begin
          rec_d     = in_rec_s;
          is_load_d = exu_lsu_bus_i[RE_BIT] & ~exu_lsu_bus_i[WE_BIT];
          op_d      = in_op_s;
          off_d     = in_addr_s[1:0];
          ready_d   = 1'b0;
          if (!in_mem_s) begin
            out_d       = in_rec_s;
            lsu_valid_d = 1'b1;
            state_d     = DONE;
          end else if (in_misalign_s) begin
            out_d            = in_rec_s;
            out_d[EXCP_BIT]  = 1'b1;
            out_d[GRWE_BIT]  = 1'b0;
            out_d[CSRWE_BIT] = 1'b0;
            lsu_valid_d      = 1'b1;
            state_d          = DONE;
          end else begin
            req_valid_d = 1'b1;
            req_wen_d   = exu_lsu_bus_i[WE_BIT];
            req_addr_d  = {in_addr_s[ADDR_W-1:2], 2'b00};
            req_wdata_d = store_data(in_op_s, exu_lsu_bus_i[WDATA_LSB +: 32]);
            req_wmask_d = store_mask(in_op_s, in_addr_s[1:0]);
            state_d     = REQ;
          end
        end else begin
          ready_d = 1'b1;
        end
      end
      REQ: begin
        if (req_ready_i) begin
          req_valid_d = 1'b0;
          state_d     = WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (resp_valid_i) begin
          out_d = rec_q;
          if (is_load_q) begin
            out_d[FR_LSB +: 32] = load_extract(op_q, off_q, resp_rdata_i);
          end else begin
            out_d[FR_LSB +: 32] = rec_q[FR_LSB +: 32];
          end
          lsu_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        ready_d     = 1'b1;
        req_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and registered-output flops with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      rec_q       <= '0;
      out_q       <= '0;
      is_load_q   <= 1'b0;
      op_q        <= 3'b000;
      off_q       <= 2'b00;
      ready_q     <= 1'b1;
      req_valid_q <= 1'b0;
      req_wen_q   <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= 32'h0000_0000;
      req_wmask_q <= 4'b0000;
      lsu_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rec_q       <= rec_d;
      out_q       <= out_d;
      is_load_q   <= is_load_d;
      op_q        <= op_d;
      off_q       <= off_d;
      ready_q     <= ready_d;
      req_valid_q <= req_valid_d;
      req_wen_q   <= req_wen_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wmask_q <= req_wmask_d;
      lsu_valid_q <= lsu_valid_d;
    end
  end

  assign lsu_ready_o   = ready_q;
  assign req_valid_o   = req_valid_q;
  assign req_wen_o     = req_wen_q;
  assign req_addr_o    = req_addr_q;
  assign req_wdata_o   = req_wdata_q;
  assign req_wmask_o   = req_wmask_q;
  assign lsu_valid_o   = lsu_valid_q;
  assign lsu_wbu_bus_o = out_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for lsu with a record/request scoreboard checked every negedge.
module tb_lsu;
  localparam int WB_W = 119;
  localparam int EX_W = 156;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            exu_valid_i = 1'b0;
  logic [EX_W-1:0] exu_lsu_bus_i = '0;
  logic            lsu_ready_o;
  logic            req_valid_o;
  logic            req_ready_i = 1'b0;
  logic            req_wen_o;
  logic [31:0]     req_addr_o;
  logic [31:0]     req_wdata_o;
  logic [3:0]      req_wmask_o;
  logic            resp_valid_i = 1'b0;
  logic [31:0]     resp_rdata_i = 32'h0000_0000;
  logic            lsu_valid_o;
  logic [WB_W-1:0] lsu_wbu_bus_o;

  always #5 clock = ~clock;

  lsu #(.ADDR_W(32)) dut (
    .clock(clock), .reset(reset), .exu_valid_i(exu_valid_i), .exu_lsu_bus_i(exu_lsu_bus_i),
    .lsu_ready_o(lsu_ready_o), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .req_wen_o(req_wen_o), .req_addr_o(req_addr_o), .req_wdata_o(req_wdata_o),
    .req_wmask_o(req_wmask_o), .resp_valid_i(resp_valid_i), .resp_rdata_i(resp_rdata_i),
    .lsu_valid_o(lsu_valid_o), .lsu_wbu_bus_o(lsu_wbu_bus_o)
  );

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int pushed = 0;
  logic [WB_W-1:0] exp_q[$];
  logic [WB_W-1:0] held = '0;
  logic [WB_W-1:0] last_rec = '0;
  logic            rst_pending = 1'b0;
  logic            exp_req_active = 1'b0;
  logic            exp_wen = 1'b0;
  logic [31:0]     exp_addr = 32'h0, exp_wdata = 32'h0;
  logic [3:0]      exp_mask = 4'h0;
  logic [31:0]     last_req_addr = 32'h0, last_req_wdata = 32'h0;
  logic [3:0]      last_req_mask = 4'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Model: what the spec says a load returns
  function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[8*addr[1:0] +: 8];
    h = rdata[16*addr[1] +: 16];
    case (op)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return rdata;
    endcase
  endfunction

  function automatic logic [31:0] m_sdata(input logic [2:0] op, input logic [31:0] wdata);
    if (op == 3'b000) return {wdata[7:0], wdata[7:0], wdata[7:0], wdata[7:0]};
    else if (op == 3'b001) return {wdata[15:0], wdata[15:0]};
    else return wdata;
  endfunction

  function automatic logic [3:0] m_mask(input logic [2:0] op, input logic [31:0] addr);
    logic [3:0] m;
    m = 4'b0000;
    if (op == 3'b000) m[addr[1:0]] = 1'b1;
    else if (op == 3'b001) begin m[2*addr[1]] = 1'b1; m[2*addr[1]+1] = 1'b1; end
    else m = 4'b1111;
    return m;
  endfunction

  function automatic bit m_misaligned(input logic [2:0] op, input logic [31:0] addr);
    if (op == 3'b000 || op == 3'b100) return 1'b0;
    else if (op == 3'b001 || op == 3'b101) return addr[0];
    else return addr[1:0] != 2'b00;
  endfunction

  function automatic logic [WB_W-1:0] make_rec(input logic [31:0] fr);
    return {1'b1, fr, 1'b1, 5'd9, 12'h341, 32'h0BAD_F00D, 1'b1, 32'h8000_0100, 1'b0, 1'b0, 1'b0};
  endfunction

  // Compare process: records on pulses, record stability between pulses, request fields while valid
  initial forever begin
    @(negedge clock);
    if (rst_pending) held = '0;
    checks++;
    if (lsu_valid_o === 1'b1) begin
      pulses++;
      last_rec = lsu_wbu_bus_o;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rec_unexpected actual=%h required=no_pulse", lsu_wbu_bus_o);
      end else begin
        held = exp_q.pop_front();
        if (lsu_wbu_bus_o !== held) begin
          errors++;
          $display("FAIL rec actual=%h required=%h", lsu_wbu_bus_o, held);
        end
      end
    end else if (lsu_wbu_bus_o !== held) begin
      errors++;
      $display("FAIL rec_hold actual=%h required=%h", lsu_wbu_bus_o, held);
    end
    if (req_valid_o === 1'b1) begin
      last_req_addr  = req_addr_o;
      last_req_wdata = req_wdata_o;
      last_req_mask  = req_wmask_o;
      checks++;
      if (!exp_req_active || req_wen_o !== exp_wen || req_addr_o !== exp_addr ||
          (exp_wen && (req_wdata_o !== exp_wdata || req_wmask_o !== exp_mask))) begin
        errors++;
        $display("FAIL req actual=%b/%h/%h/%b required=%b/%h/%h/%b active=%b", req_wen_o, req_addr_o,
                 req_wdata_o, req_wmask_o, exp_wen, exp_addr, exp_wdata, exp_mask, exp_req_active);
      end
    end
    rst_pending = reset;
  end

  task automatic run_op(input logic re, input logic we, input logic [2:0] op, input logic [31:0] wdata,
                        input logic [31:0] addr, input logic [31:0] rdata, input int rdy, input int rsp,
                        input bit spur, input bit do_reset);
    logic [WB_W-1:0] rec, exp_rec;
    bit mem, mis;
    rec = make_rec(addr);
    mem = re | we;
    mis = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    mis = mem && m_misaligned(op, addr);
`endif
    exp_rec = rec;
    if (mis) begin
      exp_rec[1] = 1'b1; exp_rec[85] = 1'b0; exp_rec[118] = 1'b0;
    end else if (mem && !we) begin
      exp_rec[117:86] = m_load(op, addr, rdata);
    end
    if (!do_reset) begin exp_q.push_back(exp_rec); pushed++; end
    if (mem && !mis) begin
      exp_req_active = 1'b1; exp_wen = we; exp_addr = {addr[31:2], 2'b00};
      exp_wdata = m_sdata(op, wdata); exp_mask = m_mask(op, addr);
    end
    exu_lsu_bus_i = {re, we, op, wdata, rec};
    exu_valid_i = 1'b1;
    step();
    exu_valid_i = 1'b0;
    if (!mem || mis) begin
      chk("nm_pulse", lsu_valid_o, 1);
      chk("nm_noreq", req_valid_o, 0);
      step();
      chk("nm_once", lsu_valid_o, 0);
      chk("nm_ready", lsu_ready_o, 1);
    end else begin
      chk("req_up", req_valid_o, 1);
      chk("busy", lsu_ready_o, 0);
      for (int i = 0; i < rdy; i++) begin
        req_ready_i = 1'b0; resp_valid_i = spur; resp_rdata_i = 32'h5555_AAAA;
        step();
        chk("req_hold", req_valid_o, 1);
        chk("no_early", lsu_valid_o, 0);
      end
      req_ready_i = 1'b1; resp_valid_i = spur; resp_rdata_i = 32'h5555_AAAA;
      step();
      req_ready_i = 1'b0; resp_valid_i = 1'b0; exp_req_active = 1'b0;
      chk("req_drop", req_valid_o, 0);
      chk("wait_quiet", lsu_valid_o, 0);
      if (do_reset) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_ready", lsu_ready_o, 1);
        chk("rst_req", req_valid_o, 0);
        chk("rst_valid", lsu_valid_o, 0);
        chk("rst_bus", {31'h0, |lsu_wbu_bus_o}, 0);
        resp_valid_i = 1'b1; resp_rdata_i = 32'h1111_2222;
        step();
        step();
        resp_valid_i = 1'b0;
        chk("stray_valid", lsu_valid_o, 0);
        chk("stray_ready", lsu_ready_o, 1);
      end else begin
        for (int i = 0; i < rsp; i++) begin
          step();
          chk("wait_hold", lsu_valid_o, 0);
        end
        resp_valid_i = 1'b1; resp_rdata_i = rdata;
        step();
        resp_valid_i = 1'b0;
        chk("done_pulse", lsu_valid_o, 1);
        step();
        chk("pulse_once", lsu_valid_o, 0);
        chk("ready_back", lsu_ready_o, 1);
      end
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    chk("rst_ready0", lsu_ready_o, 1);
    chk("rst_req0", req_valid_o, 0);
    chk("rst_wen0", req_wen_o, 0);
    chk("rst_mask0", req_wmask_o, 0);
    chk("rst_valid0", lsu_valid_o, 0);
    chk("rst_bus0", {31'h0, |lsu_wbu_bus_o}, 0);
    reset = 1'b0;
    step();

    run_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0000_1234, 32'h0, 0, 0, 1'b0, 1'b0);
    chk("nm_lit", last_rec[117:86], 32'h0000_1234);
    run_op(1'b1, 1'b0, 3'b000, 32'h0, 32'h0000_1003, 32'h80FF_0011, 0, 0, 1'b0, 1'b0);
    chk("lb_lit", last_rec[117:86], 32'hFFFF_FF80);
    run_op(1'b1, 1'b0, 3'b100, 32'h0, 32'h0000_1003, 32'h80FF_0011, 0, 0, 1'b0, 1'b0);
    chk("lbu_lit", last_rec[117:86], 32'h0000_0080);
    run_op(1'b0, 1'b1, 3'b001, 32'h0000_ABCD, 32'h0000_1002, 32'h0, 0, 0, 1'b0, 1'b0);
    chk("sh_wdata", last_req_wdata, 32'hABCD_ABCD);
    chk("sh_mask", {28'h0, last_req_mask}, 32'h0000_000C);
    chk("sh_addr", last_req_addr, 32'h0000_1000);
    chk("sh_fr", last_rec[117:86], 32'h0000_1002);
    run_op(1'b1, 1'b0, 3'b001, 32'h0, 32'h0000_2002, 32'h8001_1234, 1, 0, 1'b0, 1'b0);
    chk("lh_lit", last_rec[117:86], 32'hFFFF_8001);
    run_op(1'b1, 1'b0, 3'b101, 32'h0, 32'h0000_2000, 32'h1234_F0F0, 0, 1, 1'b0, 1'b0);
    chk("lhu_lit", last_rec[117:86], 32'h0000_F0F0);
    run_op(1'b1, 1'b0, 3'b010, 32'h0, 32'h0000_3004, 32'hCAFE_BABE, 3, 2, 1'b1, 1'b0);
    chk("lw_slow", last_rec[117:86], 32'hCAFE_BABE);
    run_op(1'b0, 1'b1, 3'b000, 32'h1234_565A, 32'h0000_4001, 32'h0, 2, 1, 1'b1, 1'b0);
    chk("sb_wdata", last_req_wdata, 32'h5A5A_5A5A);
    chk("sb_mask", {28'h0, last_req_mask}, 32'h0000_0002);
    run_op(1'b1, 1'b1, 3'b010, 32'hDEAD_BEEF, 32'h0000_5008, 32'h7777_7777, 0, 0, 1'b0, 1'b0);
    chk("rewe_store_fr", last_rec[117:86], 32'h0000_5008);
    chk("rewe_mask", {28'h0, last_req_mask}, 32'h0000_000F);
    run_op(1'b1, 1'b0, 3'b011, 32'h0, 32'h0000_6000, 32'h0102_0304, 0, 0, 1'b0, 1'b0);
    chk("op011_word", last_rec[117:86], 32'h0102_0304);
    run_op(1'b1, 1'b0, 3'b010, 32'h0, 32'h0000_7002, 32'hA5A5_0F0F, 0, 0, 1'b0, 1'b0);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("mis_excp", {31'h0, last_rec[1]}, 1);
    chk("mis_grwe", {31'h0, last_rec[85]}, 0);
`else
    chk("lw_unaligned", last_rec[117:86], 32'hA5A5_0F0F);
    chk("lw_ua_addr", last_req_addr, 32'h0000_7000);
`endif
    run_op(1'b1, 1'b0, 3'b010, 32'h0, 32'h0000_8000, 32'h9999_9999, 0, 0, 1'b0, 1'b1);
    run_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0000_00AB, 32'h0, 0, 0, 1'b0, 1'b0);
    chk("post_rst_nm", last_rec[117:86], 32'h0000_00AB);

    step();
    chk("queue_empty", exp_q.size(), 0);
    chk("pulse_count", pulses, pushed);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu.md
# lsu

Load/store stage between the execute unit and `wbu`. It accepts one instruction at a time from the execute stage and, for loads and stores, runs a single request/response transaction on the data-memory port. It then presents a completed `LSU_WBU_BUS` record to `wbu` with a one-cycle `lsu_valid_o` pulse. Non-memory instructions pass through with fixed one-cycle latency.

## Interface
- `ADDR_W`, 32: data address width.
- `clock` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `exu_valid_i` in 1: execute stage offers an instruction.
- `exu_lsu_bus_i` in `EXU_LSU_BUS_WIDTH`: `{mem_re, mem_we, mem_op[2:0], mem_wdata[31:0], <LSU_WBU_BUS fields>}`. `final_result` carries the ALU result, which is the effective address for memory ops.
- `lsu_ready_o` out 1: high only in IDLE; the instruction is accepted when `exu_valid_i && lsu_ready_o`.
- `req_valid_o` out 1: memory request valid.
- `req_ready_i` in 1: memory accepts the request.
- `req_wen_o` out 1: 1 = store.
- `req_addr_o` out `ADDR_W`: word-aligned address, `{addr[31:2],2'b00}`.
- `req_wdata_o` out 32: lane-aligned store data.
- `req_wmask_o` out 4: byte strobes.
- `resp_valid_i` in 1: response (load data or store ack).
- `resp_rdata_i` in 32: load word.
- `lsu_valid_o` out 1: one-cycle pulse, record valid.
- `lsu_wbu_bus_o` out `LSU_WBU_BUS_WIDTH`: `{csr_we, final_result, gr_we, rd, csr_addr, csr_wdata, jmp_flag, jmp_target, break, excp_flush, xret_flush}`.

## Operation
- FSM states are IDLE, REQ, WAIT and DONE.
- **IDLE, accept:** the accepted bus is latched.
  - If `mem_re|mem_we`, go to REQ.
  - Otherwise go to DONE, with `final_result` unchanged.
- **REQ:** `req_valid_o=1`. Address, wdata, wmask and wen are held stable until `req_ready_i`, then go to WAIT.
  - If `req_ready_i` and `resp_valid_i` arrive in the same cycle in REQ, the response is ignored. A response is only taken in WAIT.
- **WAIT:** on `resp_valid_i`, go to DONE.
  - For loads, `final_result` is replaced by the extracted data.
  - For stores, `final_result` is unchanged.
- **DONE:** `lsu_valid_o=1` for exactly one cycle, then IDLE.
- `resp_valid_i` outside WAIT is ignored.
- `mem_op` follows RV32 funct3:
  - 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
  - Any other value is treated as word.
- Load extraction:
  - Byte = `rdata >> (8*addr[1:0])`, sign-extended (LB) or zero-extended (LBU).
  - Half = `rdata >> (16*addr[1])`, sign-extended (LH) or zero-extended (LHU).
  - Word = `rdata`.
- Store lanes:
  - SB: wdata byte replicated 4×, mask `4'b0001<<addr[1:0]`.
  - SH: half replicated 2×, mask `4'b0011<<{addr[1],1'b0}`.
  - SW: mask `4'b1111`.
- `mem_re` and `mem_we` both set: treated as a store.

## Timing
- Reset values: state IDLE, `lsu_ready_o=1`, `req_valid_o=0`, `req_wen_o=0`, `req_wmask_o=0`, `lsu_valid_o=0`, latched bus all zero.
- Reset mid-transaction returns to IDLE next edge and drops the instruction.
  - The memory side must not deliver a response after reset. Any stray response is ignored by the WAIT-only rule.
- Non-memory latency: accept at edge N, `lsu_valid_o` high during cycle N+1.
- Memory latency: accept at N, `req_valid_o` from N+1. Completion takes 1 + request-wait cycles + response latency + 1.
  - Minimum is 4 cycles: accept, REQ with ready, WAIT with resp, DONE.
- `lsu_wbu_bus_o` stays stable from DONE until the next DONE. `wbu` samples it on the `lsu_valid_o` edge.
- No new instruction is accepted in DONE. `lsu_ready_o` rises the cycle after the pulse.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined:
  - Misalignment condition: halfword with `addr[0]=1`, or word with `addr[1:0]!=0`.
  - On a misaligned access, no memory request is issued; IDLE goes straight to DONE.
  - The output record has `excp_flush=1`, `gr_we=0` and `csr_we=0`.
- Undefined: no check. Address low bits are ignored for words, and for halves only `addr[1]` is used. The request always proceeds.

## Test plan
- Non-memory op, `final_result=32'h1234`: `lsu_valid_o` pulses exactly at cycle N+1 with `final_result=32'h1234`, and `req_valid_o` never rises.
- LB at addr `0x...03`, `rdata=32'h80FF_0011`: result `32'hFFFF_FF80`. LBU at the same address gives `32'h0000_0080`.
- SH at addr `0x...02`, `wdata=32'h0000_ABCD`: `req_wdata_o=32'hABCD_ABCD`, `req_wmask_o=4'b1100`, `req_addr_o` aligned.
- `req_ready_i` held low 3 cycles, then response delayed 2 cycles:
  - req signals stay stable throughout.
  - Exactly one `lsu_valid_o` pulse.
  - A spurious `resp_valid_i` during REQ is ignored.
- Reset asserted in WAIT: next cycle state IDLE, `req_valid_o=0`, `lsu_ready_o=1`, and no `lsu_valid_o` pulse.
- With `LSU_MISALIGN_CHECK_EN`, LW at `0x...02`: no request, `lsu_valid_o` pulses with `excp_flush=1` and `gr_we=0`.
